// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues one imem read at a time, holds the word for decode.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets trap into a sticky FAULT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [6:0]  Op,
  output logic [31:0] PC,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
`ifdef IF_MISALIGN_TRAP_EN
    , StFault
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        kill_q, kill_d;
  logic [31:0] target;

`ifdef IF_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  logic misalign;

  assign target   = PCTarget;
  assign misalign = PCSrc && (PCTarget[1:0] != 2'b00);
`else
  logic unused_tgt;

  assign target     = {PCTarget[31:2], 2'b00};
  assign unused_tgt = ^PCTarget[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    kill_d     = kill_q;
`ifdef IF_MISALIGN_TRAP_EN
    fault_d    = fault_q;
`endif
    unique case (state_q)
      StReq: begin
        // The request goes out at the old PC regardless; a redirect marks its response stale.
        state_d = StWait;
        if (PCSrc) begin
          kill_d     = 1'b1;
          fetch_pc_d = target;
        end
      end
      StWait: begin
        if (PCSrc) begin
          fetch_pc_d = target;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (PCSrc) begin
          fetch_pc_d = target;
          state_d    = StReq;
        end else if (dec_ready) begin
          fetch_pc_d = pc_q + 32'd4;
          state_d    = StReq;
        end
      end
      default: ;
    endcase
`ifdef IF_MISALIGN_TRAP_EN
    if (misalign && (state_q != StFault)) begin
      state_d = StFault;
      fault_d = 1'b1;
      kill_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0013;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      kill_q     <= kill_d;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // State sits at REQ during reset, so the request must be masked explicitly.
  assign imem_req    = (state_q == StReq) && !rst;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (state_q == StHold);
  assign Instr       = instr_q;
  assign Op          = instr_q[6:0];
  assign PC          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with configurable latency plus a second
// instance reset near the top of the address space to cover PC wrap.
module tb_instr_fetch_unit;

  localparam logic [31:0] DataOfs = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [6:0]  Op;
  logic [31:0] PC;
  logic        instr_valid;
  logic        dec_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        fetch_fault;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Memory model: responds lat cycles after the request cycle with addr + DataOfs.
  int          lat = 1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        inj = 1'b0;
  logic [31:0] inj_data = '0;

  assign imem_rvalid = mem_rvalid | inj;
  assign imem_rdata  = inj ? inj_data : mem_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= pend_addr + DataOfs;
        pend       <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (imem_req) begin
      if (lat == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= imem_addr + DataOfs;
      end else begin
        pend      <= 1'b1;
        cnt       <= lat - 1;
        pend_addr <= imem_addr;
      end
    end
  end

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .Op          (Op),
    .PC          (PC),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .fetch_fault (fetch_fault)
  );

  // Wrap instance: always ready, 1-cycle memory, logs every request address.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_instr;
  logic [6:0]  w_op;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_fault;
  logic [31:0] wlog[$];

  always @(posedge clk) begin
    w_rvalid <= w_req;
    if (w_req) wlog.push_back(w_addr);
  end

  instr_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rvalid (w_rvalid),
    .imem_rdata  (32'h0000_0013),
    .Instr       (w_instr),
    .Op          (w_op),
    .PC          (w_pc),
    .instr_valid (w_valid),
    .dec_ready   (1'b1),
    .PCSrc       (1'b0),
    .PCTarget    (32'h0000_0000),
    .fetch_fault (w_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step negedges until imem_req (sel=0) or instr_valid (sel=1) is seen, bounded.
  task automatic wait_for(input string tag, input int sel, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      seen = (sel == 0) ? imem_req : instr_valid;
      if (seen) break;
      @(negedge clk);
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    dec_ready = 1'b1;
    PCSrc     = 1'b0;
    PCTarget  = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_instr", Instr, 32'h0000_0013);
    check("rst_op", Op, 7'b0010011);
    check("rst_pc", PC, 32'h0);
    check("rst_fault", fetch_fault, 1'b0);

    rst = 1'b0;
    #1;
    check("c1_req", imem_req, 1'b1);
    check("c1_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("c2_req", imem_req, 1'b0);
    check("c2_valid", instr_valid, 1'b0);
    @(negedge clk);
    check("c3_valid", instr_valid, 1'b1);
    check("c3_op", Op, 7'b0010011);
    check("c3_pc", PC, 32'h0);
    check("c3_instr", Instr, 32'h0050_0093);
    @(negedge clk);
    check("c4_req", imem_req, 1'b1);
    check("c4_addr", imem_addr, 32'h4);
    check("c4_valid", instr_valid, 1'b0);

    // Stall five cycles in HOLD.
    dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", instr_valid, 1'b1);
      check("stall_req", imem_req, 1'b0);
      check("stall_pc", PC, 32'h4);
      check("stall_instr", Instr, 32'h0050_0097);
      @(negedge clk);
    end
    dec_ready = 1'b1;
    @(negedge clk);
    check("release_req", imem_req, 1'b1);
    check("release_addr", imem_addr, 32'h8);

    // Redirect from HOLD.
    repeat (2) @(negedge clk);
    check("hold8_pc", PC, 32'h8);
    PCSrc     = 1'b1;
    PCTarget  = 32'h0000_0100;
    dec_ready = 1'b0;
    @(negedge clk);
    PCSrc = 1'b0;
    check("rh_req", imem_req, 1'b1);
    check("rh_addr", imem_addr, 32'h100);
    check("rh_valid", instr_valid, 1'b0);
    repeat (2) @(negedge clk);
    check("rh_hold_valid", instr_valid, 1'b1);
    check("rh_hold_pc", PC, 32'h100);
    check("rh_hold_instr", Instr, 32'h0050_0193);

    // Redirect in WAIT with 3-cycle memory; stale response must be dropped.
    lat       = 3;
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    check("rw_addr0", imem_addr, 32'h104);
    @(negedge clk);
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0200;
    @(negedge clk);
    PCSrc = 1'b0;
    check("rw_novalid", instr_valid, 1'b0);
    wait_for("rw_req_seen", 0, 8);
    check("rw_valid_at_req", instr_valid, 1'b0);
    check("rw_addr", imem_addr, 32'h200);
    @(negedge clk);
    wait_for("rw_valid_seen", 1, 12);
    check("rw_first_pc", PC, 32'h200);
    check("rw_first_instr", Instr, 32'h0050_0293);

    // Response with nothing outstanding is ignored.
    lat      = 1;
    inj_data = 32'hDEAD_BEEF;
    inj      = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    check("spur_valid", instr_valid, 1'b1);
    check("spur_instr", Instr, 32'h0050_0293);
    check("spur_pc", PC, 32'h200);
    @(negedge clk);
    check("spur_req", imem_req, 1'b0);

    // Misaligned redirect.
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0102;
    @(negedge clk);
    PCSrc = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      check("mis_fault", fetch_fault, 1'b1);
      check("mis_req", imem_req, 1'b0);
      check("mis_valid", instr_valid, 1'b0);
      @(negedge clk);
    end
`else
    check("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_fault", fetch_fault, 1'b0);
    @(negedge clk);
`endif

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #1;
    check("mrst_valid", instr_valid, 1'b0);
    check("mrst_req", imem_req, 1'b0);
    check("mrst_pc", PC, 32'h0);
    check("mrst_instr", Instr, 32'h0000_0013);
    check("mrst_fault", fetch_fault, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_req1", imem_req, 1'b1);
    check("mrst_addr1", imem_addr, 32'h0);

    check("wrap_log_len", 32'(wlog.size() >= 2), 32'd1);
    if (wlog.size() >= 2) begin
      check("wrap_addr0", wlog[0], 32'hFFFF_FFFC);
      check("wrap_addr1", wlog[1], 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
